// File: rtl/multi_register_file_pkg.sv
// Shared definitions for the multi-register file.
//   funsel_t : 3-bit operation select
//   FS_*     : operation encodings applied to every enabled register
package multi_register_file_pkg;

  typedef logic [2:0] funsel_t;

  localparam funsel_t FS_HOLD   = 3'b000;
  localparam funsel_t FS_CLEAR  = 3'b001;
  localparam funsel_t FS_LOAD   = 3'b010;
  localparam funsel_t FS_DEC    = 3'b011;
  localparam funsel_t FS_INC    = 3'b100;
  localparam funsel_t FS_LOADLO = 3'b101;
  localparam funsel_t FS_LOADHI = 3'b110;
  localparam funsel_t FS_SWAP   = 3'b111;

endpackage

// File: rtl/multi_register_file_register_cell.sv
// One NBits register that executes the shared funsel operation when enabled.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : write enable for this register
//   funsel     : operation select
//   i          : load data
//   q          : current register contents
//   hit        : combinational, high when this edge would INC all-ones or DEC zero
module register_cell
  import multi_register_file_pkg::*;
#(
  parameter int NBits   = 16,
  parameter int SatMode = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  funsel_t          funsel,
  input  logic [NBits-1:0] i,
  output logic [NBits-1:0] q,
  output logic             hit
);

  localparam int H = NBits / 2;

  logic [NBits-1:0] data_d, data_q;
  logic             at_max, at_zero;

  assign at_max  = &data_q;
  assign at_zero = ~|data_q;

  always_comb begin
    data_d = data_q;
    hit    = 1'b0;
    if (en) begin
      case (funsel)
        FS_CLEAR:  data_d = '0;
        FS_LOAD:   data_d = i;
        FS_DEC: begin
          // Boundary is flagged in both modes; only the resulting value differs.
          if (at_zero) begin
            hit    = 1'b1;
            data_d = (SatMode != 0) ? data_q : '1;
          end else begin
            data_d = data_q - NBits'(1);
          end
        end
        FS_INC: begin
          if (at_max) begin
            hit    = 1'b1;
            data_d = (SatMode != 0) ? data_q : '0;
          end else begin
            data_d = data_q + NBits'(1);
          end
        end
        FS_LOADLO: data_d = {data_q[NBits-1:H], i[H-1:0]};
        FS_LOADHI: data_d = {i[H-1:0], data_q[H-1:0]};
        FS_SWAP:   data_d = {data_q[H-1:0], data_q[NBits-1:H]};
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/multi_register_file.sv
// Bank of NRegs registers of NBits each sharing one function select.
//   clk, rst_n     : clock, asynchronous active-low reset
//   funsel         : operation applied to every register enabled in rsel
//   rsel           : one bit per register write enable
//   i              : load data
//   osel_a, osel_b : combinational read selects (out-of-range reads 0)
//   oa, ob         : read data
//   wrap           : registered, high for one cycle after any enabled register
//                    hit INC-of-all-ones or DEC-of-zero
module multi_register_file
  import multi_register_file_pkg::*;
#(
  parameter int NBits   = 16,
  parameter int NRegs   = 4,
  parameter int SatMode = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               funsel,
  input  logic [NRegs-1:0]         rsel,
  input  logic [NBits-1:0]         i,
  input  logic [$clog2(NRegs)-1:0] osel_a,
  input  logic [$clog2(NRegs)-1:0] osel_b,
  output logic [NBits-1:0]         oa,
  output logic [NBits-1:0]         ob,
  output logic                     wrap
);

  localparam int SelW = $clog2(NRegs);

  logic [NBits-1:0] regs [NRegs];
  logic [NRegs-1:0] hit;
  logic             wrap_d, wrap_q;

  for (genvar k = 0; k < NRegs; k++) begin : g_cell
    register_cell #(
      .NBits   (NBits),
      .SatMode (SatMode)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (rsel[k]),
      .funsel (funsel_t'(funsel)),
      .i      (i),
      .q      (regs[k]),
      .hit    (hit[k])
    );
  end

  // Default of zero covers unused select codes when NRegs is not a power of two.
  always_comb begin
    oa = '0;
    ob = '0;
    for (int unsigned k = 0; k < NRegs; k++) begin
      if (osel_a == SelW'(k)) oa = regs[k];
      if (osel_b == SelW'(k)) ob = regs[k];
    end
  end

  assign wrap_d = |hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule
